// File: rtl/uart_frame_parser_if.sv
// Byte-stream handshakes around the frame parser: receiver bytes in, verified payload out.
interface uart_frame_parser_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] rxdata;
    logic                  rxvalid;
    logic                  rxready;
    logic [DATA_WIDTH-1:0] pdata;
    logic                  pvalid;
    logic                  pready;
    logic                  plast;

    modport master (input rxdata, rxvalid, pready, output rxready, pdata, pvalid, plast);
    modport slave  (output rxdata, rxvalid, pready, input rxready, pdata, pvalid, plast);
endinterface

// File: rtl/uart_frame_parser.sv
// Finds SYNC/LEN/payload/CSUM frames in the UART byte stream and releases a buffered
// payload only once its checksum has verified.
module uart_frame_parser #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    MAX_LEN    = 16,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hA5,
    parameter int                    TIMEOUT    = 20000
) (
    input  logic                       clk,
    input  logic                       rstn,
    uart_frame_parser_if.master        bus,
    output logic                       frame_ok,
    output logic                       frame_err,
    output logic [7:0]                 err_cnt
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_SYNC, S_LEN, S_PAY, S_CSUM, S_OUT} state_t;
    state_t state, state_d;

    logic [DATA_WIDTH-1:0] pbuf [MAX_LEN];
    logic [DATA_WIDTH-1:0] len, sum, idx, rd;
    logic [TW-1:0]         idle;
    logic acc, in_frame, timed_out, len_bad, csum_good, out_hs, drop, ok;

    assign bus.rxready = (state != S_OUT);
    assign acc         = bus.rxvalid && bus.rxready;
    assign in_frame    = (state == S_LEN) || (state == S_PAY) || (state == S_CSUM);
    // Firing on the edge where the count would reach TIMEOUT puts frame_err exactly
    // TIMEOUT clocks after the last accepted byte.
    assign timed_out   = in_frame && !acc && (idle == TW'(TIMEOUT - 1));
    assign len_bad     = (bus.rxdata == '0) || (bus.rxdata > DATA_WIDTH'(MAX_LEN));
    assign csum_good   = (DATA_WIDTH'(sum + bus.rxdata) == '0);

    assign bus.pvalid  = (state == S_OUT);
    assign bus.pdata   = bus.pvalid ? pbuf[rd[AW-1:0]] : '0;
    assign bus.plast   = bus.pvalid && (rd == len - 1'b1);
    assign out_hs      = bus.pvalid && bus.pready;

    always_comb begin
        state_d = state;
        drop    = 1'b0;
        ok      = 1'b0;
        case (state)
            S_SYNC: if (acc && bus.rxdata == SYNC_BYTE) state_d = S_LEN;
            S_LEN: if (acc) begin
                if (len_bad) begin
                    drop    = 1'b1;
                    state_d = S_SYNC;
                end else begin
                    state_d = S_PAY;
                end
            end
            S_PAY: if (acc && idx == len - 1'b1) state_d = S_CSUM;
            S_CSUM: if (acc) begin
                if (csum_good) begin
                    ok      = 1'b1;
                    state_d = S_OUT;
                end else begin
                    drop    = 1'b1;
                    state_d = S_SYNC;
                end
            end
            S_OUT: if (out_hs && bus.plast) state_d = S_SYNC;
            default: state_d = S_SYNC;
        endcase
        if (timed_out) begin
            drop    = 1'b1;
            state_d = S_SYNC;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_SYNC;
            len       <= '0;
            sum       <= '0;
            idx       <= '0;
            rd        <= '0;
            idle      <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_d;
            frame_ok  <= ok;
            frame_err <= drop;
            if (drop && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
            idle <= (!in_frame || acc) ? '0 : idle + 1'b1;
            if (acc && state == S_LEN) begin
                len <= bus.rxdata;
                sum <= bus.rxdata;
                idx <= '0;
            end
            if (acc && state == S_PAY) begin
                sum <= sum + bus.rxdata;
                idx <= idx + 1'b1;
            end
            if (ok)          rd <= '0;
            else if (out_hs) rd <= rd + 1'b1;
        end
    end

    // Payload storage needs no reset; rd/len gate what is ever presented.
    always_ff @(posedge clk) begin
        if (acc && state == S_PAY) pbuf[idx[AW-1:0]] <= bus.rxdata;
    end
endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed and randomized frames against a frame-level reference model.
module tb_uart_frame_parser;
    localparam int DW = 8;
    localparam int ML = 16;
    localparam int TO = 40;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       frame_ok, frame_err;
    logic [7:0] err_cnt;

    uart_frame_parser_if #(.DATA_WIDTH(DW)) bus ();

    uart_frame_parser #(.DATA_WIDTH(DW), .MAX_LEN(ML), .SYNC_BYTE(8'hA5), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int ncmp = 0, nfail = 0;
    int cyc = 0, acc_cyc = 0, pmode = 0;
    // monitor-owned
    logic [8:0] got_q[$];
    int         gcyc_q[$];
    int         ok_cnt = 0, errp_cnt = 0, ok_cyc = 0, err_cyc = 0, hold_bad = 0, rx_bad = 0;
    bit         prev_stall = 0;
    logic [8:0] prev_out = '0;
    // model-owned
    logic [8:0] exp_q[$];
    logic [7:0] pay_q[$];
    int         exp_ok = 0, exp_err = 0, drops = 0, cmp_idx = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.pready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (pmode)
                0:       bus.pready = 1'b1;
                1:       bus.pready = ~bus.pready;
                default: bus.pready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (frame_ok)  begin ok_cnt++;   ok_cyc  = cyc; end
        if (frame_err) begin errp_cnt++; err_cyc = cyc; end
        if (bus.pvalid && bus.rxready) rx_bad++;
        if (prev_stall && (!bus.pvalid || {bus.plast, bus.pdata} != prev_out)) hold_bad++;
        if (bus.pvalid && bus.pready) begin
            got_q.push_back({bus.plast, bus.pdata});
            gcyc_q.push_back(cyc);
        end
        prev_stall = bus.pvalid && !bus.pready && rstn;
        prev_out   = {bus.plast, bus.pdata};
    end

    initial begin
        #800000;
        $fatal(1, "FAIL watchdog: time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rxdata  = b;
        bus.rxvalid = 1'b1;
        @(negedge clk);
        while (!bus.rxready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("rx_accept_wait", 32'(bus.rxready), 1);
        @(posedge clk);
        #1;
        acc_cyc     = cyc;
        bus.rxvalid = 1'b0;
        bus.rxdata  = 8'($urandom);
    endtask

    task automatic gap(input int maxgap);
        int g = $urandom_range(0, maxgap);
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    // kind 0: good, 1: corrupted checksum, 2: illegal length (payload in pay_q)
    task automatic send_frame(input int kind, input int maxgap);
        logic [7:0] len, s;
        if (kind == 2) begin
            len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(ML + 1, 255));
            send_byte(8'hA5); gap(maxgap); send_byte(len);
            exp_err++; drops++;
            return;
        end
        len = 8'(pay_q.size());
        s   = len;
        send_byte(8'hA5); gap(maxgap); send_byte(len);
        foreach (pay_q[i]) begin
            gap(maxgap);
            send_byte(pay_q[i]);
            s = s + pay_q[i];
        end
        gap(maxgap);
        if (kind == 0) begin
            send_byte(~s + 8'd1);
            foreach (pay_q[i]) exp_q.push_back({(i == pay_q.size() - 1), pay_q[i]});
            exp_ok++;
        end else begin
            send_byte(~s + 8'd1 + 8'($urandom_range(1, 255)));
            exp_err++; drops++;
        end
    endtask

    task automatic rand_payload(input int len);
        pay_q.delete();
        for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
    endtask

    task automatic settle(input string tag);
        int n = 0;
        while ((got_q.size() < exp_q.size() || ok_cnt != exp_ok || errp_cnt != exp_err
                || bus.pvalid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_nout"}, got_q.size(), exp_q.size());
        check({tag, "_nok"}, ok_cnt, exp_ok);
        check({tag, "_nerr"}, errp_cnt, exp_err);
        check({tag, "_errcnt"}, err_cnt, (drops > 255) ? 255 : drops);
        check({tag, "_hold"}, hold_bad, 0);
        check({tag, "_rxblock"}, rx_bad, 0);
        for (int i = cmp_idx; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_byte"}, got_q[i], exp_q[i]);
        cmp_idx = exp_q.size();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base, a;
        logic [7:0] j;
        bus.rxvalid = 1'b0;
        bus.rxdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rxready", bus.rxready, 1);
        check("rst_pvalid", bus.pvalid, 0);
        check("rst_plast", bus.plast, 0);
        check("rst_pdata", bus.pdata, 0);
        check("rst_frame_ok", frame_ok, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // good frame, hand-computed checksum
        base = exp_q.size();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
        a = acc_cyc;
        exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b0, 8'h22}); exp_q.push_back({1'b1, 8'h33});
        exp_ok++;
        settle("good");
        check("good_ok_latency", ok_cyc - a, 0);
        if (gcyc_q.size() >= base + 3) begin
            check("good_first_out", gcyc_q[base] - a, 0);
            check("good_consec1", gcyc_q[base + 1] - gcyc_q[base], 1);
            check("good_consec2", gcyc_q[base + 2] - gcyc_q[base + 1], 1);
        end

        // junk ahead of sync, single-byte frame
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
        exp_q.push_back({1'b1, 8'h7F});
        exp_ok++;
        settle("junk");

        // bad checksum, zero length, oversize length
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h98);
        send_byte(8'hA5); send_byte(8'h00);
        send_byte(8'hA5); send_byte(8'h11);
        exp_err += 3; drops += 3;
        settle("bad");

        // backpressure, second frame right behind the first
        pmode = 1;
        rand_payload(4); send_frame(0, 0);
        rand_payload(6); send_frame(0, 0);
        settle("bp");
        pmode = 0;

        // timeout mid-payload, then recovery
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        a = acc_cyc;
        exp_err++; drops++;
        settle("tmo");
        check("tmo_latency", err_cyc - a, TO);
        rand_payload(5); send_frame(0, 2);
        settle("tmo_next");

        // randomized mix, including length boundaries 1 and MAX_LEN
        for (int f = 0; f < 30; f++) begin
            int kind, len, r;
            pmode = $urandom_range(0, 2);
            r     = $urandom_range(0, 7);
            kind  = (r < 6) ? 0 : ((r == 6) ? 1 : 2);
            len   = (f == 0) ? 1 : ((f == 1) ? ML : $urandom_range(1, ML));
            rand_payload(len);
            if ($urandom_range(0, 3) == 0) begin
                do j = 8'($urandom); while (j == 8'hA5);
                send_byte(j);
            end
            send_frame(kind, 3);
        end
        settle("rand");
        pmode = 0;

        // error counter saturation
        for (int k = 0; k < 260; k++) begin
            send_byte(8'hA5); send_byte(8'h00);
        end
        exp_err += 260; drops += 260;
        settle("sat");

        // asynchronous reset mid-payload
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_rxready", bus.rxready, 1);
        check("mid_rst_pvalid", bus.pvalid, 0);
        check("mid_rst_plast", bus.plast, 0);
        check("mid_rst_pdata", bus.pdata, 0);
        check("mid_rst_frame_ok", frame_ok, 0);
        check("mid_rst_frame_err", frame_err, 0);
        check("mid_rst_err_cnt", err_cnt, 0);
        drops = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2 * TO) @(posedge clk);
        #1;
        check("post_rst_no_err", errp_cnt, exp_err);
        check("post_rst_no_out", got_q.size(), exp_q.size());
        pay_q.delete();
        for (int i = 1; i <= 4; i++) pay_q.push_back(8'(i));
        send_frame(0, 0);
        settle("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
